// File: rtl/srec_loader_pkg.sv
// Shared types and constants for the S-record loader: FSM states, byte-lane
// geometry and the default end-of-load idle timeout.
package srec_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADING = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } load_state_t;

    localparam int BYTE_LANES           = 4;
    localparam int LANE_BITS            = 2;
    localparam int DEFAULT_IDLE_TIMEOUT = 5000000;

    // One-hot byte enable for a byte lane within a 32-bit word.
    function automatic logic [BYTE_LANES-1:0] lane_onehot(input logic [LANE_BITS-1:0] lane);
        return BYTE_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/srec_word_packer.sv
// Collects parser bytes into one 32-bit word buffer; signals an eviction when a
// byte for a different word arrives or when the loader flushes a valid buffer.
module srec_word_packer
    import srec_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [31:0]           wr_address,
    input  logic [7:0]            wr_byte,
    output logic                  valid,
    output logic                  evict,
    output logic [ADDR_WIDTH-1:0] evict_address,
    output logic [31:0]           evict_data,
    output logic [BYTE_LANES-1:0] evict_byte_en
);

    logic                  buf_valid_r;
    logic [ADDR_WIDTH-1:0] buf_word_r;
    logic [31:0]           buf_data_r;
    logic [BYTE_LANES-1:0] buf_be_r;

    logic [ADDR_WIDTH-1:0] in_word_s;
    logic [LANE_BITS-1:0]  in_lane_s;
    logic [BYTE_LANES-1:0] lane_be_s;
    logic [31:0]           fresh_data_s;
    logic [31:0]           merge_data_s;
    logic                  hit_s;

    assign in_word_s = wr_address[ADDR_WIDTH+1:LANE_BITS];
    assign in_lane_s = wr_address[LANE_BITS-1:0];

    // Lane placement for a fresh word and for a merge into the buffered word.
    always_comb begin
        lane_be_s    = lane_onehot(in_lane_s);
        fresh_data_s = 32'h0000_0000;
        merge_data_s = buf_data_r;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (lane_be_s[i]) begin
                fresh_data_s[8*i +: 8] = wr_byte;
                merge_data_s[8*i +: 8] = wr_byte;
            end else begin
                fresh_data_s[8*i +: 8] = 8'h00;
                merge_data_s[8*i +: 8] = buf_data_r[8*i +: 8];
            end
        end
        hit_s = buf_valid_r && (buf_word_r == in_word_s);
        evict = (wr && buf_valid_r && !hit_s) || (flush && buf_valid_r);
    end

    // Buffer register: clear dominates, then byte capture, then flush.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            buf_valid_r <= 1'b0;
            buf_word_r  <= '0;
            buf_data_r  <= 32'h0000_0000;
            buf_be_r    <= '0;
        end else if (wr) begin
            if (hit_s) begin
                buf_data_r <= merge_data_s;
                buf_be_r   <= buf_be_r | lane_be_s;
            end else begin
                buf_valid_r <= 1'b1;
                buf_word_r  <= in_word_s;
                buf_data_r  <= fresh_data_s;
                buf_be_r    <= lane_be_s;
            end
        end else if (flush) begin
            buf_valid_r <= 1'b0;
            buf_be_r    <= '0;
        end
    end

    assign valid         = buf_valid_r;
    assign evict_address = buf_word_r;
    assign evict_data    = buf_data_r;
    assign evict_byte_en = buf_be_r;

endmodule

// File: rtl/srec_load_arbiter.sv
// Owns the program-memory port: packs loader bytes into word writes while the
// CPU is held in reset, then hands the port to the CPU after an idle timeout.
module srec_load_arbiter
    import srec_loader_pkg::*;
#(
    parameter int ADDR_WIDTH    = 30,
    parameter int IDLE_TIMEOUT  = DEFAULT_IDLE_TIMEOUT,
    parameter int TIMEOUT_WIDTH = 23
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           wr_address,
    input  logic [7:0]            wr_byte,
    input  logic                  wr_enable,
    input  logic                  format_error,
    input  logic                  checksum_error,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_byte_en,
    output logic                  cpu_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byte_en,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           word_count
);

    load_state_t state_r;
    load_state_t state_n;

    logic [TIMEOUT_WIDTH-1:0] idle_cnt_r;

    logic err_s;
    logic pk_wr_s;
    logic pk_clear_s;
    logic pk_flush_s;
    logic cpu_grant_s;
    logic wc_clear_s;
    logic idle_clear_s;
    logic idle_inc_s;
    logic timeout_s;

    logic                  pk_valid_s;
    logic                  pk_evict_s;
    logic [ADDR_WIDTH-1:0] pk_address_s;
    logic [31:0]           pk_data_s;
    logic [3:0]            pk_byte_en_s;

    assign err_s     = format_error | checksum_error;
    assign timeout_s = (idle_cnt_r == TIMEOUT_WIDTH'(IDLE_TIMEOUT - 1));

    srec_word_packer #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_packer (
        .clock         (clock),
        .reset         (reset),
        .clear         (pk_clear_s),
        .flush         (pk_flush_s),
        .wr            (pk_wr_s),
        .wr_address    (wr_address),
        .wr_byte       (wr_byte),
        .valid         (pk_valid_s),
        .evict         (pk_evict_s),
        .evict_address (pk_address_s),
        .evict_data    (pk_data_s),
        .evict_byte_en (pk_byte_en_s)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state and per-cycle control strobes; errors always win over writes.
    always_comb begin
        state_n      = state_r;
        pk_wr_s      = 1'b0;
        pk_clear_s   = 1'b0;
        pk_flush_s   = 1'b0;
        cpu_grant_s  = 1'b0;
        wc_clear_s   = 1'b0;
        idle_clear_s = 1'b0;
        idle_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (err_s) begin
                    state_n    = ST_ERROR;
                    pk_clear_s = 1'b1;
                end else if (wr_enable) begin
                    state_n      = ST_LOADING;
                    pk_wr_s      = 1'b1;
                    wc_clear_s   = 1'b1;
                    idle_clear_s = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOADING: begin
                if (err_s) begin
                    state_n    = ST_ERROR;
                    pk_clear_s = 1'b1;
                end else if (wr_enable) begin
                    pk_wr_s      = 1'b1;
                    idle_clear_s = 1'b1;
                end else if (timeout_s) begin
                    state_n      = ST_FLUSH;
                    idle_clear_s = 1'b1;
                end else begin
                    idle_inc_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (err_s) begin
                    state_n    = ST_ERROR;
                    pk_clear_s = 1'b1;
                end else begin
                    state_n    = ST_DONE;
                    pk_flush_s = 1'b1;
                end
            end
            ST_DONE: begin
                if (err_s) begin
                    state_n    = ST_ERROR;
                    pk_clear_s = 1'b1;
                end else if (wr_enable) begin
                    state_n      = ST_LOADING;
                    pk_wr_s      = 1'b1;
                    wc_clear_s   = 1'b1;
                    idle_clear_s = 1'b1;
                end else begin
                    // The ack cycle itself never re-grants; a held request waits one cycle.
                    cpu_grant_s = cpu_req && !cpu_ack;
                end
            end
            ST_ERROR: begin
                state_n    = ST_ERROR;
                pk_clear_s = 1'b1;
            end
            default: begin
                state_n    = ST_IDLE;
                pk_clear_s = 1'b1;
            end
        endcase
    end

    // End-of-load idle counter.
    always_ff @(posedge clock) begin
        if (reset || idle_clear_s) begin
            idle_cnt_r <= '0;
        end else if (idle_inc_s) begin
            idle_cnt_r <= idle_cnt_r + TIMEOUT_WIDTH'(1);
        end
    end

    // Memory port mux: loader evictions and CPU grants are mutually exclusive by state.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= 32'h0000_0000;
            mem_byte_en <= 4'h0;
            cpu_ack     <= 1'b0;
        end else if (pk_evict_s) begin
            mem_we      <= 1'b1;
            mem_re      <= 1'b0;
            mem_address <= pk_address_s;
            mem_wdata   <= pk_data_s;
            mem_byte_en <= pk_byte_en_s;
            cpu_ack     <= 1'b0;
        end else if (cpu_grant_s) begin
            mem_we      <= cpu_we;
            mem_re      <= !cpu_we;
            mem_address <= cpu_address;
            mem_wdata   <= cpu_wdata;
            mem_byte_en <= cpu_byte_en;
            cpu_ack     <= 1'b1;
        end else begin
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= 32'h0000_0000;
            mem_byte_en <= 4'h0;
            cpu_ack     <= 1'b0;
        end
    end

    // Status outputs follow the state being entered so they change with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= 16'h0000;
        end else begin
            cpu_reset  <= (state_n != ST_DONE);
            load_done  <= (state_n == ST_DONE);
            load_error <= (state_n == ST_ERROR);
            if (wc_clear_s) begin
                word_count <= 16'h0000;
            end else if (pk_evict_s && (word_count != 16'hFFFF)) begin
                word_count <= word_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_srec_load_arbiter.sv
// Randomized and directed bench for srec_load_arbiter; loader writes are
// checked against word groups derived from the byte stream of each load.
module tb_srec_load_arbiter;

    localparam int AW = 30;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   wr_address = 32'h0;
    logic [7:0]    wr_byte = 8'h0;
    logic          wr_enable = 1'b0;
    logic          format_error = 1'b0;
    logic          checksum_error = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_address = '0;
    logic [31:0]   cpu_wdata = 32'h0;
    logic [3:0]    cpu_byte_en = 4'h0;
    logic          cpu_ack;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byte_en;
    logic          mem_we;
    logic          mem_re;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [15:0]   word_count;

    int tests_run = 0;
    int tests_failed = 0;
    int ack_seen = 0;
    int stray_reads = 0;

    logic [39:0] load_q[$];
    wr_t         obs_q[$];
    wr_t         exp_q[$];

    srec_load_arbiter #(
        .ADDR_WIDTH    (AW),
        .IDLE_TIMEOUT  (16),
        .TIMEOUT_WIDTH (5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wr_address     (wr_address),
        .wr_byte        (wr_byte),
        .wr_enable      (wr_enable),
        .format_error   (format_error),
        .checksum_error (checksum_error),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .cpu_byte_en    (cpu_byte_en),
        .cpu_ack        (cpu_ack),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_en    (mem_byte_en),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .cpu_reset      (cpu_reset),
        .load_done      (load_done),
        .load_error     (load_error),
        .word_count     (word_count)
    );

    always #5 clock = ~clock;

    // Observe the memory port mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_we && !cpu_ack) obs_q.push_back('{a: mem_address, d: mem_wdata, be: mem_byte_en});
            if (cpu_ack) ack_seen++;
            if (mem_re && !cpu_ack) stray_reads++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic send_byte(input logic [31:0] addr, input logic [7:0] data, input bit record);
        wr_address = addr;
        wr_byte    = data;
        wr_enable  = 1'b1;
        if (record) load_q.push_back({addr, data});
        step();
        wr_enable = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check_eq({tag, "_load_done"}, load_done, 1'b0);
        check_eq({tag, "_load_error"}, load_error, 1'b0);
        check_eq({tag, "_word_count"}, word_count, 16'h0);
        check_eq({tag, "_mem_port"}, {mem_we, mem_re, cpu_ack, mem_byte_en, mem_address, mem_wdata}, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        step();
        check_reset_values(tag);
        reset = 1'b0;
        load_q.delete();
        obs_q.delete();
    endtask

    task automatic begin_load();
        load_q.delete();
        obs_q.delete();
    endtask

    // Group consecutive bytes by word: each change of word, and the end of the load, emits one write.
    task automatic build_expected();
        wr_t         e;
        bit          have;
        logic [31:0] a;
        exp_q.delete();
        have = 0;
        e = '0;
        foreach (load_q[k]) begin
            a = load_q[k][39:8];
            if (have && e.a != a[31:2]) begin
                exp_q.push_back(e);
                have = 0;
            end
            if (!have) begin
                e    = '0;
                e.a  = a[31:2];
                have = 1;
            end
            e.d[a[1:0]*8 +: 8] = load_q[k][7:0];
            e.be[a[1:0]]       = 1'b1;
        end
        if (have) exp_q.push_back(e);
    endtask

    task automatic finish_load(input string tag);
        int n;
        build_expected();
        for (int i = 0; i < 100 && !load_done; i++) step();
        check_eq({tag, "_done_in_time"}, load_done, 1'b1);
        step();
        step();
        check_eq({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_addr"}, obs_q[k].a, exp_q[k].a);
            check_eq({tag, "_be"}, obs_q[k].be, exp_q[k].be);
            check_eq({tag, "_data"}, obs_q[k].d & lane_mask(exp_q[k].be), exp_q[k].d & lane_mask(exp_q[k].be));
        end
        check_eq({tag, "_word_count"}, word_count, exp_q.size());
        check_eq({tag, "_status"}, {cpu_reset, load_done, load_error}, 3'b010);
        load_q.delete();
        obs_q.delete();
    endtask

    task automatic cpu_access(input string tag, input logic we, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_address = addr;
        cpu_wdata   = wdata;
        cpu_byte_en = be;
        step();
        check_eq({tag, "_ack"}, cpu_ack, 1'b1);
        check_eq({tag, "_we_re"}, {mem_we, mem_re}, {we, !we});
        check_eq({tag, "_addr"}, mem_address, addr);
        check_eq({tag, "_wdata"}, mem_wdata, wdata);
        check_eq({tag, "_be"}, mem_byte_en, be);
        cpu_req = 1'b0;
        step();
        check_eq({tag, "_ack_drop"}, {cpu_ack, mem_we, mem_re}, 3'b000);
    endtask

    task automatic load_scenario1(input string tag);
        begin_load();
        for (int i = 0; i < 4; i++) send_byte(32'h100 + i, 8'(8'h11 * (i + 1)), 1);
        check_eq({tag, "_held"}, {cpu_reset, load_done}, 2'b10);
        finish_load(tag);
    endtask

    initial begin
        int acks0;
        logic [31:0] addr;
        logic [31:0] rnd;

        step();
        step();
        check_reset_values("por");
        reset = 1'b0;
        step();

        load_scenario1("s1");

        cpu_access("s4", 1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            cpu_access("cpu_rnd", rnd[0], AW'($urandom), $urandom, 4'($urandom_range(1, 15)));
        end
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        step();
        check_eq("rearb_1", cpu_ack, 1'b1);
        step();
        check_eq("rearb_2", cpu_ack, 1'b0);
        step();
        check_eq("rearb_3", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        step();
        check_eq("rearb_4", cpu_ack, 1'b0);

        begin_load();
        send_byte(32'h102, 8'hAA, 1);
        send_byte(32'h200, 8'hBB, 1);
        check_eq("s2_evict_we", mem_we, 1'b1);
        check_eq("s2_evict_addr", mem_address, 30'h40);
        check_eq("s2_evict_be", mem_byte_en, 4'b0100);
        check_eq("s2_evict_byte", mem_wdata[23:16], 8'hAA);
        finish_load("s2");

        begin_load();
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        acks0   = ack_seen;
        send_byte(32'h500, 8'h5A, 1);
        check_eq("s5_no_ack", cpu_ack, 1'b0);
        check_eq("s5_status", {cpu_reset, load_done}, 2'b10);
        check_eq("s5_word_count", word_count, 16'h0);
        send_byte(32'h504, 8'h6B, 1);
        step();
        step();
        check_eq("s5_no_ack_loading", ack_seen, acks0);
        cpu_req = 1'b0;
        finish_load("s5");

        for (int r = 0; r < 6; r++) begin
            begin_load();
            addr = {20'h0, 10'($urandom), 2'($urandom)};
            for (int b = 0; b < 1 + $urandom_range(0, 11); b++) begin
                send_byte(addr, 8'($urandom), 1);
                rnd = $urandom_range(0, 9);
                if (rnd < 5) addr = {addr[31:2], 2'($urandom)};
                else if (rnd < 8) addr = addr + 32'd4;
                else addr = {20'h0, 10'($urandom), 2'($urandom)};
                repeat ($urandom_range(0, 8)) step();
            end
            finish_load("rnd_load");
        end

        do_reset("s3_rst");
        send_byte(32'h300, 8'h01, 1);
        send_byte(32'h301, 8'h02, 1);
        checksum_error = 1'b1;
        send_byte(32'h400, 8'h77, 0);
        checksum_error = 1'b0;
        repeat (40) step();
        check_eq("s3_no_write", obs_q.size(), 0);
        check_eq("s3_status", {cpu_reset, load_done, load_error}, 3'b101);
        acks0   = ack_seen;
        cpu_req = 1'b1;
        repeat (10) step();
        check_eq("s3_no_ack", ack_seen, acks0);
        cpu_req = 1'b0;
        send_byte(32'h800, 8'h99, 0);
        repeat (40) step();
        check_eq("s3_sticky", {obs_q.size() == 0, load_error, cpu_reset}, 3'b111);

        do_reset("s6_rst0");
        send_byte(32'h600, 8'hC1, 1);
        send_byte(32'h601, 8'hC2, 1);
        do_reset("s6_rst_mid");
        repeat (40) step();
        check_eq("s6_no_write", obs_q.size(), 0);
        check_eq("s6_idle_status", {cpu_reset, load_done, word_count}, {1'b1, 1'b0, 16'h0});
        load_scenario1("s6_reload");

        check_eq("stray_reads", stray_reads, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/srec_load_arbiter.md
Name: srec_load_arbiter

Overview:
- Sits between srec_parser's byte-write stream and a single-port 32-bit program memory.
- Packs parser bytes into word writes with byte enables. Holds the CPU in reset while a load is in progress.
- Detects end-of-load by an idle timeout, then hands the memory port to the CPU.
- Aborts and latches an error on any parser format or checksum error.

Parameters:
- ADDR_WIDTH, 30, word-address bits driven to memory (byte address bits [ADDR_WIDTH+1:2]).
- IDLE_TIMEOUT, 5000000, cycles with no parser write after which the load is complete (100 ms at 50 MHz).
- TIMEOUT_WIDTH, 23, width of the idle counter; must hold IDLE_TIMEOUT-1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_address  in  32  parser byte address.
- wr_byte  in  8  parser data byte.
- wr_enable  in  1  one-cycle strobe: wr_byte is valid for wr_address.
- format_error  in  1  parser format error (level).
- checksum_error  in  1  parser checksum error (level).
- cpu_req  in  1  CPU memory request, held until cpu_ack.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_address  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_byte_en  in  4  CPU byte enables.
- cpu_ack  out  1  one-cycle CPU request acknowledge.
- mem_address  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  32  memory write data.
- mem_byte_en  out  4  memory byte enables.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe (read data is wired memory-to-CPU outside this block).
- cpu_reset  out  1  holds the CPU in reset.
- load_done  out  1  last load completed cleanly.
- load_error  out  1  sticky parser error.
- word_count  out  16  number of loader word writes issued in the current load.

Behaviour:
- Reset values:
  - state = IDLE, cpu_reset = 1.
  - All mem_* = 0, cpu_ack = 0, load_done = 0, load_error = 0, word_count = 0.
  - Pack buffer invalid, idle counter = 0.
- All outputs are registered.
- States: IDLE, LOADING, FLUSH, DONE, ERROR.
- IDLE:
  - cpu_reset = 1; the CPU port is ignored.
  - wr_enable -> LOADING; the byte is captured into the buffer.
- LOADING (cpu_reset = 1, per wr_enable):
  - Lane = wr_address[1:0]; word = wr_address[ADDR_WIDTH+1:2].
  - Buffer empty: load word, place byte in lane bits [8*lane+7:8*lane], set byte_en[lane].
  - Same word: merge; a repeated lane is overwritten by the later byte.
  - Different word: next cycle mem_we = 1 for exactly one cycle with the old word/data/byte_en; buffer reloads with the new byte; word_count += 1 (saturates at 16'hFFFF). No stall is needed.
- Idle counter (LOADING only):
  - Clears on every wr_enable, otherwise increments.
  - Reaching IDLE_TIMEOUT-1 -> FLUSH.
- FLUSH (one cycle):
  - If the buffer is valid, mem_we pulses with the buffered word; word_count += 1.
  - Buffer is cleared -> DONE.
- DONE:
  - cpu_reset = 0 and load_done = 1, from the cycle after FLUSH.
  - CPU port: cpu_req with no wr_enable in the same cycle -> next cycle mem_* mirror the CPU request (mem_we = cpu_we, mem_re = !cpu_we) and cpu_ack = 1, one cycle.
  - One access per req; after an ack, a still-high cpu_req is re-arbitrated the following cycle.
- New load from DONE:
  - wr_enable -> LOADING. cpu_reset = 1 and load_done = 0 next cycle; word_count clears to 0, then counts this load.
  - Simultaneous cpu_req is not acked; the loader wins.
- Errors:
  - format_error | checksum_error in IDLE, LOADING, FLUSH or DONE -> ERROR.
  - The buffer is discarded with no write. load_error = 1, cpu_reset = 1, load_done = 0.
  - Error and wr_enable in the same cycle: the error wins and the byte is dropped.
  - ERROR is left only by reset; cpu_req is never acked there.
- cpu_req outside DONE: no ack, no mem activity.
- Reset mid-load: the partial word is lost, with no write; everything returns to reset values.

Decomposition:
- srec_loader_pkg:
  - state enum (IDLE, LOADING, FLUSH, DONE, ERROR).
  - BYTE_LANES = 4, LANE_BITS = 2.
  - Default IDLE_TIMEOUT constant.
- One sub-module: srec_word_packer.
  - Holds buffer valid, word address, data, byte_en.
  - Merge / evict / flush / clear controls.
  - Produces the evicted-word outputs.
- The FSM, idle counter and port mux stay in srec_load_arbiter.

Test Plan (bench runs with IDLE_TIMEOUT = 16):
1. Bytes 0x11, 0x22, 0x33, 0x44 to addresses 0x100–0x103, then idle -> one write after timeout: mem_address = 0x40, mem_wdata = 0x44332211, mem_byte_en = 4'hF. Then cpu_reset falls, load_done = 1, word_count = 1.
2. Bytes to 0x102 (0xAA) then 0x200 (0xBB) -> write at 0x40, wdata[23:16] = 0xAA, byte_en = 4'b0100, the cycle after the second strobe. FLUSH then writes 0x80, byte_en = 4'b0001, wdata[7:0] = 0xBB. word_count = 2.
3. Two bytes, then checksum_error pulse -> no mem_we ever. load_error = 1, cpu_reset stays 1. Later cpu_req is never acked.
4. In DONE: cpu_req with cpu_we = 1, address 0x10, wdata 0xDEADBEEF, byte_en 4'hF -> next cycle mem_we = 1 with those values and cpu_ack = 1 for one cycle.
5. In DONE: cpu_req and wr_enable in the same cycle -> no cpu_ack. State goes LOADING, cpu_reset = 1 and load_done = 0 next cycle, word_count = 0.
6. Assert reset with a half-filled buffer -> no write. All outputs return to reset values; a subsequent load behaves as in scenario 1.
